// File: rtl/jk_pkg.sv
// Shared types and the per-bit JK excitation rule used by the JK bank driver.
package jk_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    DRIVE = 2'd2,
    CHECK = 2'd3
  } jk_state_e;

  // Returns {j, k} that moves one JK flip-flop from cur to nxt; xfill resolves the don't-care.
  function automatic logic [1:0] jk_excite_bit(input logic cur, input logic nxt, input logic xfill);
    logic [1:0] jk;
    unique case ({cur, nxt})
      2'b00:   jk = {1'b0, xfill};
      2'b01:   jk = {1'b1, xfill};
      2'b10:   jk = {xfill, 1'b1};
      default: jk = {xfill, 1'b0};
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite_driver_if.sv
// Target handshake plus the J/K drive and Q feedback of one JK register bank.
//
// Handshake: a target word transfers on a rising clk edge where tgt_valid and
// tgt_ready are both high. The source holds tgt_valid and tgt_data stable until
// that edge; tgt_ready depends only on the driver state, never on tgt_valid.
interface jk_excite_driver_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_fb;
  logic             done;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] model_q;

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j, k, done, mismatch, err_cnt, model_q
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j, k, done, mismatch, err_cnt, model_q
  );
endinterface

// File: rtl/jk_excite.sv
// Combinational WIDTH-bit JK excitation: J/K that moves each flop from i_cur to i_nxt.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit XFILL = 1'b0
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_nxt,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  always_comb begin
    o_j = '0;
    o_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {o_j[i], o_k[i]} = jk_excite_bit(i_cur[i], i_nxt[i], XFILL);
    end
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK register bank toward accepted target words and self-checks the
// bank's Q feedback one cycle after each drive.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit XFILL = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  jk_excite_driver_if.slave bus,
  output jk_state_e         o_dbg_state
);

  jk_state_e        r_state;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_done;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] r_model_q;

  jk_state_e        w_state_nxt;
  logic [WIDTH-1:0] w_tgt_nxt;
  logic [WIDTH-1:0] w_j_nxt;
  logic [WIDTH-1:0] w_k_nxt;
  logic             w_done_nxt;
  logic             w_mismatch_nxt;
  logic [CNT_W-1:0] w_err_cnt_nxt;
  logic [WIDTH-1:0] w_model_q_nxt;
  logic [WIDTH-1:0] w_exc_j;
  logic [WIDTH-1:0] w_exc_k;

  // Excitation is taken from the tracked state, which is refreshed from q_fb
  // at every check, so a target accepted in the done cycle sees the real bank.
  jk_excite #(
    .WIDTH (WIDTH),
    .XFILL (XFILL)
  ) u_excite (
    .i_cur (r_model_q),
    .i_nxt (bus.tgt_data),
    .o_j   (w_exc_j),
    .o_k   (w_exc_k)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_tgt_nxt      = r_tgt;
    w_j_nxt        = '0;
    w_k_nxt        = '0;
    w_done_nxt     = 1'b0;
    w_mismatch_nxt = 1'b0;
    w_err_cnt_nxt  = r_err_cnt;
    w_model_q_nxt  = r_model_q;
    case (r_state)
      INIT: begin
        w_state_nxt = IDLE;
      end
      IDLE: begin
        if (bus.tgt_valid) begin
          w_tgt_nxt   = bus.tgt_data;
          w_j_nxt     = w_exc_j;
          w_k_nxt     = w_exc_k;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        w_state_nxt = CHECK;
      end
      CHECK: begin
        w_done_nxt     = 1'b1;
        w_mismatch_nxt = (bus.q_fb != r_tgt);
        if (w_mismatch_nxt && (r_err_cnt != '1)) begin
          w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
        w_model_q_nxt = bus.q_fb;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // K is all-ones out of reset so the bank is cleared while rst is held and
  // once more during INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_tgt      <= '0;
      r_j        <= '0;
      r_k        <= '1;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
      r_model_q  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt      <= w_tgt_nxt;
      r_j        <= w_j_nxt;
      r_k        <= w_k_nxt;
      r_done     <= w_done_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_model_q  <= w_model_q_nxt;
    end
  end

  assign bus.tgt_ready = (r_state == IDLE);
  assign bus.j         = r_j;
  assign bus.k         = r_k;
  assign bus.done      = r_done;
  assign bus.mismatch  = r_mismatch;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.model_q   = r_model_q;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: two instances (XFILL=0/CNT_W=8 and XFILL=1/CNT_W=2)
// in lockstep, each closing the loop through a behavioural JK bank.
module tb_jk_excite_driver;
  import jk_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_excite_driver_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
  jk_excite_driver_if #(.WIDTH(4), .CNT_W(2)) bus_b ();
  jk_state_e st_a;
  jk_state_e st_b;

  jk_excite_driver #(.WIDTH(4), .XFILL(1'b0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .o_dbg_state(st_a)
  );
  jk_excite_driver #(.WIDTH(4), .XFILL(1'b1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .o_dbg_state(st_b)
  );

  // ---------------- behavioural JK banks ----------------
  logic [3:0] bank_a = 4'b1011;
  logic [3:0] bank_b = 4'b0110;
  logic       force_load = 1'b0;
  logic [3:0] force_val  = 4'b0000;

  // force_load makes the bank capture force_val instead of following J/K.
  always @(posedge clk) begin
    bank_a <= force_load ? force_val : ((bus_a.j & ~bank_a) | (~bus_a.k & bank_a));
    bank_b <= force_load ? force_val : ((bus_b.j & ~bank_b) | (~bus_b.k & bank_b));
  end
  assign bus_a.q_fb = bank_a;
  assign bus_b.q_fb = bank_b;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  logic [15:0] jk_q[$];    // {j_a, k_a, j_b, k_b}
  logic [14:0] done_q[$];  // {mismatch, err_a, err_b, model_q}
  logic [7:0]  exp_err_a = 8'd0;
  logic [1:0]  exp_err_b = 2'd0;
  logic [15:0] mon_jk;
  logic [14:0] mon_done;
  logic acc_d1 = 1'b0, acc_d2 = 1'b0, acc_d3 = 1'b0;
  logic [3:0]  t7_data [0:8];
  logic [15:0] t7_jk   [0:2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not seen / unexpected event", name);
  endtask

  task automatic push_exp(input logic [3:0] tgt, input logic fen, input logic [3:0] fval,
                          input logic [3:0] ja, input logic [3:0] ka,
                          input logic [3:0] jb, input logic [3:0] kb);
    logic [3:0] q;
    logic       mis;
    q   = fen ? fval : tgt;
    mis = (q != tgt);
    if (mis) begin
      if (exp_err_a != 8'hFF) exp_err_a = exp_err_a + 8'd1;
      if (exp_err_b != 2'd3)  exp_err_b = exp_err_b + 2'd1;
    end
    jk_q.push_back({ja, ka, jb, kb});
    done_q.push_back({mis, exp_err_a, exp_err_b, q});
  endtask

  // Accept pipeline: done must follow an accept by exactly three edges.
  always @(posedge clk) begin
    if (rst) begin
      acc_d1 <= 1'b0;
      acc_d2 <= 1'b0;
      acc_d3 <= 1'b0;
    end else begin
      acc_d1 <= bus_a.tgt_valid && bus_a.tgt_ready;
      acc_d2 <= acc_d1;
      acc_d3 <= acc_d2;
    end
  end

  always @(negedge clk) begin
    if (acc_d1) begin
      acc_cnt++;
      if (jk_q.size() == 0) fail_msg("jk_unexpected_accept");
      else begin
        mon_jk = jk_q.pop_front();
        check("drive_j_a", bus_a.j, mon_jk[15:12]);
        check("drive_k_a", bus_a.k, mon_jk[11:8]);
        check("drive_j_b", bus_b.j, mon_jk[7:4]);
        check("drive_k_b", bus_b.k, mon_jk[3:0]);
      end
    end
    if (acc_d3 || bus_a.done || bus_b.done) begin
      check("done_a", bus_a.done, acc_d3);
      check("done_b", bus_b.done, acc_d3);
      if (acc_d3) begin
        if (done_q.size() == 0) fail_msg("done_unexpected");
        else begin
          mon_done = done_q.pop_front();
          check("mismatch_a", bus_a.mismatch, mon_done[14]);
          check("err_cnt_a",  bus_a.err_cnt,  mon_done[13:6]);
          check("model_q_a",  bus_a.model_q,  mon_done[3:0]);
          check("mismatch_b", bus_b.mismatch, mon_done[14]);
          check("err_cnt_b",  bus_b.err_cnt,  mon_done[5:4]);
          check("model_q_b",  bus_b.model_q,  mon_done[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1 phase) ----------------
  task automatic send(input logic [3:0] tgt, input logic fen, input logic [3:0] fval,
                      input logic [3:0] ja, input logic [3:0] ka,
                      input logic [3:0] jb, input logic [3:0] kb);
    int budget;
    budget = 0;
    bus_a.tgt_valid = 1'b1; bus_a.tgt_data = tgt;
    bus_b.tgt_valid = 1'b1; bus_b.tgt_data = tgt;
    @(negedge clk);
    while (!bus_a.tgt_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus_a.tgt_ready) begin
      fail_msg("ready_timeout");
      bus_a.tgt_valid = 1'b0;
      bus_b.tgt_valid = 1'b0;
      return;
    end
    push_exp(tgt, fen, fval, ja, ka, jb, kb);
    @(posedge clk); #1;
    bus_a.tgt_valid = 1'b0; bus_a.tgt_data = ~tgt;
    bus_b.tgt_valid = 1'b0; bus_b.tgt_data = ~tgt;
    force_load = fen;
    force_val  = fval;
    @(posedge clk); #1;
    force_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk); #1;
    while (done_q.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_q.size() != 0) fail_msg("drain_timeout");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus_a.tgt_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus_a.tgt_ready) fail_msg("idle_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc_start;
    t7_data = '{4'b1001, 4'b1111, 4'b0000, 4'b0011, 4'b1100, 4'b1010, 4'b1100, 4'b0110, 4'b1011};
    t7_jk   = '{{4'b1000, 4'b0100, 4'b1101, 4'b1110},
                {4'b0010, 4'b1000, 4'b1011, 4'b1110},
                {4'b1100, 4'b0011, 4'b1111, 4'b1111}};
    bus_a.tgt_valid = 1'b0; bus_a.tgt_data = 4'b0000;
    bus_b.tgt_valid = 1'b0; bus_b.tgt_data = 4'b0000;

    // Reset held two edges, then the INIT cycle, then IDLE.
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_j_a", bus_a.j, 4'b0000);
    check("rst_k_a", bus_a.k, 4'b1111);
    check("rst_k_b", bus_b.k, 4'b1111);
    check("rst_done_a", bus_a.done, 1'b0);
    check("rst_err_a", bus_a.err_cnt, 8'd0);
    check("rst_model_a", bus_a.model_q, 4'b0000);
    check("rst_ready_a", bus_a.tgt_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("init_j_a", bus_a.j, 4'b0000);
    check("init_k_a", bus_a.k, 4'b1111);
    check("init_ready_a", bus_a.tgt_ready, 1'b0);
    @(posedge clk); @(negedge clk);
    check("idle_ready_a", bus_a.tgt_ready, 1'b1);
    check("idle_j_a", bus_a.j, 4'b0000);
    check("idle_k_a", bus_a.k, 4'b0000);
    check("idle_k_b", bus_b.k, 4'b0000);
    check("idle_err_a", bus_a.err_cnt, 8'd0);
    check("idle_model_a", bus_a.model_q, 4'b0000);
    check("bank_cleared_a", bank_a, 4'b0000);
    check("bank_cleared_b", bank_b, 4'b0000);
    @(posedge clk); #1;

    // Basic drives, XFILL contrast, hold target with forced mismatch.
    send(4'b1010, 1'b0, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1111);
    send(4'b0110, 1'b0, 4'b0000, 4'b0100, 4'b1000, 4'b1110, 4'b1101);
    send(4'b0110, 1'b1, 4'b0111, 4'b0000, 4'b0000, 4'b0110, 4'b1001);
    send(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0111, 4'b0111, 4'b1111);
    drain();

    // Reset during DRIVE aborts the target and clears the counter.
    wait_idle();
    bus_a.tgt_valid = 1'b1; bus_a.tgt_data = 4'b1111;
    bus_b.tgt_valid = 1'b1; bus_b.tgt_data = 4'b1111;
    jk_q.push_back({4'b1111, 4'b0000, 4'b1111, 4'b1111});
    @(posedge clk); #1;
    bus_a.tgt_valid = 1'b0;
    bus_b.tgt_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_j_a", bus_a.j, 4'b0000);
    check("abort_k_a", bus_a.k, 4'b1111);
    check("abort_k_b", bus_b.k, 4'b1111);
    check("abort_done_a", bus_a.done, 1'b0);
    check("abort_err_a", bus_a.err_cnt, 8'd0);
    check("abort_err_b", bus_b.err_cnt, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err_a = 8'd0;
    exp_err_b = 2'd0;

    // Five forced mismatches: the 2-bit counter saturates at 3.
    send(4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    send(4'b0001, 1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b1110);
    send(4'b0011, 1'b1, 4'b0111, 4'b0000, 4'b0000, 4'b0011, 4'b1100);
    send(4'b0111, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0111, 4'b1000);
    send(4'b1111, 1'b1, 4'b1110, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    send(4'b0101, 1'b0, 4'b0000, 4'b0001, 4'b1010, 4'b1111, 4'b1011);
    drain();

    // tgt_valid held high with data changing every cycle.
    wait_idle();
    acc_start = acc_cnt;
    bus_a.tgt_valid = 1'b1;
    bus_b.tgt_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      bus_a.tgt_data = t7_data[c];
      bus_b.tgt_data = t7_data[c];
      if (c > 0) @(negedge clk);
      check("stream_ready", bus_a.tgt_ready, (c % 3) == 0);
      if ((c % 3) == 0) begin
        push_exp(t7_data[c], 1'b0, 4'b0000, t7_jk[c/3][15:12], t7_jk[c/3][11:8],
                 t7_jk[c/3][7:4], t7_jk[c/3][3:0]);
      end
    end
    @(posedge clk); #1;
    bus_a.tgt_valid = 1'b0;
    bus_b.tgt_valid = 1'b0;
    drain();
    check("stream_accepts", acc_cnt - acc_start, 3);
    check("final_model_a", bus_a.model_q, 4'b1100);
    check("jk_q_empty", jk_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
